// File: rtl/spartan_cpu_pkg.sv
// Shared definitions for the CPU front end: word/address widths and the
// PC-strobe priority-select encoding used by the PC unit and its sequencing.
package spartan_cpu_pkg;

    localparam int WORD_W         = 16;
    localparam int ADDR_W_DEFAULT = 16;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_INC  = 3'd1;
    localparam logic [2:0] SEL_REL  = 3'd2;
    localparam logic [2:0] SEL_LOAD = 3'd3;
    localparam logic [2:0] SEL_CALL = 3'd4;
    localparam logic [2:0] SEL_RET  = 3'd5;

    // Return wins over call, call over load, load over relative, relative over increment.
    function automatic logic [2:0] pc_priority_sel(
        input logic ret,
        input logic call,
        input logic load,
        input logic rel,
        input logic inc
    );
        logic [2:0] sel;
        sel = SEL_NONE;
        if (ret)       sel = SEL_RET;
        else if (call) sel = SEL_CALL;
        else if (load) sel = SEL_LOAD;
        else if (rel)  sel = SEL_REL;
        else if (inc)  sel = SEL_INC;
        return sel;
    endfunction

endpackage

// File: rtl/pc_unit_return_stack.sv
// return_stack: LIFO of return addresses with level, full/empty flags and
// single-cycle overflow/underflow pulses. Pop data is the current top entry.
module return_stack #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LVL_W-1:0]  sp_q;
    logic [LVL_W-1:0]  sp_d;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (sp_q == LVL_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign level_o = sp_q;

    // With sp == DEPTH the low pointer bits wrap to 0, so rd_idx still lands on DEPTH-1.
    assign wr_idx = sp_q[PTR_W-1:0];
    assign rd_idx = wr_idx - PTR_W'(1);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~pop_i & ~full_o;

    assign overflow_o  = push_i & ~pop_i & full_o;
    assign underflow_o = pop_i & empty_o;
    assign pop_data_o  = mem[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + LVL_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry contents need no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter and instruction-fetch front end with strobe priority
// and, when PC_RETURN_STACK_EN is defined, a hardware return-address stack.
module pc_unit
    import spartan_cpu_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                STACK_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_increment,
    input  logic              pc_load,
    input  logic              pc_load_rel,
    input  logic              pc_call,
    input  logic              pc_ret,
    input  logic [WORD_W-1:0] d_bus,
    input  logic [WORD_W-1:0] i_rdata,
    output logic [ADDR_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_bus,
    output logic [ADDR_W-1:0] pc_value,
    output logic [3:0]        stack_level,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    logic [2:0]        sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_rel;
    logic              ret_ok;
    logic [ADDR_W-1:0] ret_addr;

    assign sel      = pc_priority_sel(pc_ret, pc_call, pc_load, pc_load_rel, pc_increment);
    assign target   = d_bus[ADDR_W-1:0];
    assign pc_plus1 = pc_q + ADDR_W'(1);
    // Sign extension above ADDR_W cannot affect the result modulo 2^ADDR_W.
    assign pc_rel   = pc_q + target;

    assign i_addr   = pc_q;
    assign pc_value = pc_q;
    assign i_bus    = i_rdata;

`ifdef PC_RETURN_STACK_EN
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    logic              push;
    logic              pop;
    logic              stk_empty;
    logic              stk_full_unused;
    logic              ovf_pulse;
    logic              unf_pulse;
    logic              ovf_q;
    logic              unf_q;
    logic [ADDR_W-1:0] pop_data;
    logic [LVL_W-1:0]  lvl;

    assign push = (sel == SEL_CALL);
    assign pop  = (sel == SEL_RET);

    return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .LVL_W  (LVL_W)
    ) u_return_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_plus1),
        .pop_data_o  (pop_data),
        .full_o      (stk_full_unused),
        .empty_o     (stk_empty),
        .level_o     (lvl),
        .overflow_o  (ovf_pulse),
        .underflow_o (unf_pulse)
    );

    assign ret_ok   = ~stk_empty;
    assign ret_addr = pop_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_pulse;
            unf_q <= unf_q | unf_pulse;
        end
    end

    assign stack_level     = 4'(lvl);
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
`else
    localparam int depth_unused = STACK_DEPTH;

    // Without a stack a return is a plain increment and a call a plain load.
    assign ret_ok          = 1'b0;
    assign ret_addr        = pc_plus1;
    assign stack_level     = 4'd0;
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_RET:  pc_d = ret_ok ? ret_addr : pc_plus1;
            SEL_CALL: pc_d = target;
            SEL_LOAD: pc_d = target;
            SEL_REL:  pc_d = pc_rel;
            SEL_INC:  pc_d = pc_plus1;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a queue-based reference model predicts PC, stack
// level and sticky flags per step; results are checked one cycle after each strobe.
module tb_pc_unit;
    import spartan_cpu_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [15:0] RV    = 16'h0010;
    localparam logic [15:0] XMASK = 16'h5A5A;

    logic        clk;
    logic        rst_n;
    logic        pc_increment, pc_load, pc_load_rel, pc_call, pc_ret;
    logic [15:0] d_bus;
    logic [15:0] i_rdata;
    logic [15:0] i_addr;
    logic [15:0] i_bus;
    logic [15:0] pc_value;
    logic [3:0]  stack_level;
    logic        stack_overflow;
    logic        stack_underflow;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [3:0]  lvl;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_stack[$];
    logic [15:0] m_pc;
    logic        m_ovf;
    logic        m_unf;
    int          tests_run = 0;
    int          failures  = 0;

    pc_unit #(
        .ADDR_W       (16),
        .RESET_VECTOR (RV),
        .STACK_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_increment    (pc_increment),
        .pc_load         (pc_load),
        .pc_load_rel     (pc_load_rel),
        .pc_call         (pc_call),
        .pc_ret          (pc_ret),
        .d_bus           (d_bus),
        .i_rdata         (i_rdata),
        .i_addr          (i_addr),
        .i_bus           (i_bus),
        .pc_value        (pc_value),
        .stack_level     (stack_level),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    // Instruction memory stand-in: a combinational function of the address.
    assign i_rdata = i_addr ^ XMASK;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_expected(input string tag);
        exp_t e;
        e.tag = tag;
        e.pc  = m_pc;
        e.lvl = 4'(m_stack.size());
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            failures++;
            $error("FAIL scoreboard: no expected entry, observed pc=%h", pc_value);
            return;
        end
        e = sb_q.pop_front();
        $display("[TB] %s: i_addr=%h i_bus=%h lvl=%0d ovf=%b unf=%b (want pc=%h lvl=%0d ovf=%b unf=%b)",
                 e.tag, i_addr, i_bus, stack_level, stack_overflow, stack_underflow,
                 e.pc, e.lvl, e.ovf, e.unf);
        tests_run++;
        assert (i_addr === e.pc) else begin
            failures++;
            $error("FAIL %s i_addr observed=%h expected=%h", e.tag, i_addr, e.pc);
        end
        tests_run++;
        assert (pc_value === e.pc) else begin
            failures++;
            $error("FAIL %s pc_value observed=%h expected=%h", e.tag, pc_value, e.pc);
        end
        tests_run++;
        assert (i_bus === (e.pc ^ XMASK)) else begin
            failures++;
            $error("FAIL %s i_bus observed=%h expected=%h", e.tag, i_bus, e.pc ^ XMASK);
        end
        tests_run++;
        assert (stack_level === e.lvl) else begin
            failures++;
            $error("FAIL %s stack_level observed=%0d expected=%0d", e.tag, stack_level, e.lvl);
        end
        tests_run++;
        assert ({stack_overflow, stack_underflow} === {e.ovf, e.unf}) else begin
            failures++;
            $error("FAIL %s ovf/unf observed=%b%b expected=%b%b", e.tag,
                   stack_overflow, stack_underflow, e.ovf, e.unf);
        end
    endtask

    task automatic model_reset();
        m_pc  = RV;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_step(input logic ret, input logic call, input logic load,
                              input logic rel, input logic inc, input logic [15:0] d);
        logic [2:0] s;
        s = SEL_NONE;
        if (ret)       s = SEL_RET;
        else if (call) s = SEL_CALL;
        else if (load) s = SEL_LOAD;
        else if (rel)  s = SEL_REL;
        else if (inc)  s = SEL_INC;
        case (s)
            SEL_RET: begin
`ifdef PC_RETURN_STACK_EN
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc  = m_pc + 16'd1;
                    m_unf = 1'b1;
                end
`else
                m_pc = m_pc + 16'd1;
`endif
            end
            SEL_CALL: begin
`ifdef PC_RETURN_STACK_EN
                if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 16'd1);
                else m_ovf = 1'b1;
`endif
                m_pc = d;
            end
            SEL_LOAD: m_pc = d;
            SEL_REL:  m_pc = m_pc + d;
            SEL_INC:  m_pc = m_pc + 16'd1;
            default:  m_pc = m_pc;
        endcase
    endtask

    task automatic step(input logic ret, input logic call, input logic load,
                        input logic rel, input logic inc, input logic [15:0] d,
                        input string tag);
        @(negedge clk);
        pc_ret       = ret;
        pc_call      = call;
        pc_load      = load;
        pc_load_rel  = rel;
        pc_increment = inc;
        d_bus        = d;
        model_step(ret, call, load, rel, inc, d);
        push_expected(tag);
        @(posedge clk);
        #1;
        pc_ret       = 1'b0;
        pc_call      = 1'b0;
        pc_load      = 1'b0;
        pc_load_rel  = 1'b0;
        pc_increment = 1'b0;
        check_out();
    endtask

    initial begin
        rst_n        = 1'b1;
        pc_increment = 1'b0;
        pc_load      = 1'b0;
        pc_load_rel  = 1'b0;
        pc_call      = 1'b0;
        pc_ret       = 1'b0;
        d_bus        = 16'h0000;

        // Reset is seen before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        push_expected("reset_async");
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 16'h0000, "reset_hold");

        // Increment across the wrap point.
        step(0, 0, 1, 0, 0, 16'hFFFE, "load_fffe");
        step(0, 0, 0, 0, 1, 16'h0000, "inc_ffff");
        step(0, 0, 0, 0, 1, 16'h0000, "inc_wrap_0000");
        step(0, 0, 0, 0, 1, 16'h0000, "inc_0001");

        // Relative and absolute loads, with priority over increment.
        step(0, 0, 1, 0, 0, 16'h0100, "load_0100");
        step(0, 0, 0, 1, 0, 16'hFFFC, "rel_minus4");
        step(0, 0, 1, 0, 0, 16'hABCD, "load_abcd");
        step(0, 0, 1, 0, 1, 16'h0200, "load_beats_inc");
        step(0, 0, 0, 1, 1, 16'h0010, "rel_beats_inc");

        step(0, 0, 1, 0, 0, 16'h0040, "load_0040");
        step(0, 1, 0, 0, 0, 16'h0300, "call_0300");
        step(1, 0, 0, 0, 0, 16'h0000, "ret_0041");
        step(0, 1, 0, 0, 0, 16'h0500, "call_0500");
        step(1, 1, 0, 0, 0, 16'h0700, "ret_beats_call");
        step(0, 1, 1, 0, 0, 16'h0600, "call_beats_load");
        step(1, 0, 0, 0, 0, 16'h0000, "ret_after_call");

`ifdef PC_RETURN_STACK_EN
        // Overflow on the (DEPTH+1)th nested call, underflow on the final return.
        step(0, 0, 1, 0, 0, 16'h0000, "load_0000");
        for (int i = 0; i <= DEPTH; i++) begin
            step(0, 1, 0, 0, 0, 16'h1000 + 16'(i * 16), $sformatf("nest_call_%0d", i));
        end
        for (int i = 0; i <= DEPTH; i++) begin
            step(1, 0, 0, 0, 0, 16'h0000, $sformatf("unwind_ret_%0d", i));
        end
        step(0, 0, 0, 0, 1, 16'h0000, "flags_sticky");
`else
        step(0, 1, 0, 0, 0, 16'h0300, "call_as_load");
        step(1, 0, 0, 0, 0, 16'h0000, "ret_as_inc");
        step(1, 1, 0, 0, 0, 16'h0900, "ret_inc_beats_call");
`endif

        // Reset asserted mid-call, away from a clock edge.
        step(0, 1, 0, 0, 0, 16'h0800, "call_before_reset");
        @(negedge clk);
        pc_call = 1'b1;
        d_bus   = 16'h0900;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        push_expected("reset_mid_call");
        check_out();
        @(negedge clk);
        pc_call = 1'b0;
        rst_n   = 1'b1;
        step(0, 0, 0, 0, 0, 16'h0000, "after_reset_hold");
        step(0, 0, 0, 0, 1, 16'h0000, "after_reset_inc");

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
